dct_quantizer: RTL and testbench



---
 rtl/jpeg_pkg.sv | 61 ++++++
 rtl/quant_lane.sv | 48 ++++
 rtl/dct_quantizer.sv | 91 +++++++++
 tb/tb_dct_quantizer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_pkg.sv
// rtl/jpeg_pkg.sv - shared widths, JPEG luminance tables and FSM states for the quantizer
package jpeg_pkg;

  localparam int ADDR_W   = 15;
  localparam int NUM_ROWS = 32768;
  localparam int COEF_W   = 10;
  localparam int OUT_W    = 8;
  localparam int RECIP_W  = 16;

  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(NUM_ROWS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Rows listed column 0 first; entry (r,i) lands at bits [(r*8+i)*8 +: 8].
  function automatic logic [63:0] q_row(input int r);
    case (r)
      0:       q_row = {8'd16, 8'd11, 8'd10, 8'd16, 8'd24,  8'd40,  8'd51,  8'd61};
      1:       q_row = {8'd12, 8'd12, 8'd14, 8'd19, 8'd26,  8'd58,  8'd60,  8'd55};
      2:       q_row = {8'd14, 8'd13, 8'd16, 8'd24, 8'd40,  8'd57,  8'd69,  8'd56};
      3:       q_row = {8'd14, 8'd17, 8'd22, 8'd29, 8'd51,  8'd87,  8'd80,  8'd62};
      4:       q_row = {8'd18, 8'd22, 8'd37, 8'd56, 8'd68,  8'd109, 8'd103, 8'd77};
      5:       q_row = {8'd24, 8'd35, 8'd55, 8'd64, 8'd81,  8'd104, 8'd113, 8'd92};
      6:       q_row = {8'd49, 8'd64, 8'd78, 8'd87, 8'd103, 8'd121, 8'd120, 8'd101};
      default: q_row = {8'd72, 8'd92, 8'd95, 8'd98, 8'd112, 8'd100, 8'd103, 8'd99};
    endcase
  endfunction

  function automatic logic [511:0] build_q();
    logic [511:0] t;
    logic [63:0]  row;
    t = '0;
    for (int r = 0; r < 8; r++) begin
      row = q_row(r);
      for (int i = 0; i < 8; i++) begin
        t[(r*8+i)*8 +: 8] = row[(7-i)*8 +: 8];
      end
    end
    return t;
  endfunction

  localparam logic [511:0] Q_TABLE = build_q();

  function automatic logic [1023:0] build_recip();
    logic [1023:0] t;
    int            q;
    t = '0;
    for (int e = 0; e < 64; e++) begin
      q = int'(Q_TABLE[e*8 +: 8]);
      t[e*RECIP_W +: RECIP_W] = RECIP_W'((65536 + q / 2) / q);
    end
    return t;
  endfunction

  localparam logic [1023:0] RECIP_TABLE = build_recip();

endpackage

// File: rtl/quant_lane.sv
// rtl/quant_lane.sv - one coefficient lane: capture, magnitude x reciprocal, round, sign, saturate
module quant_lane
  import jpeg_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [COEF_W-1:0]  coef,
  input  logic [RECIP_W-1:0] recip,
  output logic [OUT_W-1:0]   q
);

  localparam int PW = COEF_W + RECIP_W;
  localparam logic [PW-1:0] HALF = PW'(1) << (RECIP_W - 1);

  logic [COEF_W-1:0] coef_q;
  logic [COEF_W-1:0] mag;
  logic [PW-1:0]     prod_q;
  logic              neg_q;
  logic [COEF_W:0]   qmag;

  // -512 maps to 512, which still fits the unsigned 10-bit magnitude.
  assign mag  = coef_q[COEF_W-1] ? (~coef_q + 1'b1) : coef_q;
  assign qmag = (COEF_W+1)'((prod_q + HALF) >> RECIP_W);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      coef_q <= '0;
      prod_q <= '0;
      neg_q  <= 1'b0;
    end else begin
      coef_q <= coef;
      prod_q <= {{RECIP_W{1'b0}}, mag} * {{COEF_W{1'b0}}, recip};
      neg_q  <= coef_q[COEF_W-1];
    end
  end

  always_comb begin
    q = '0;
    if (neg_q) begin
      if (qmag > (COEF_W+1)'(128)) q = 8'h80;
      else                         q = OUT_W'(~qmag + 1'b1);
    end else begin
      if (qmag > (COEF_W+1)'(127)) q = 8'h7f;
      else                         q = OUT_W'(qmag);
    end
  end

endmodule

// File: rtl/dct_quantizer.sv
// rtl/dct_quantizer.sv - streams DCT rows through eight quantizer lanes into the output SRAM
module dct_quantizer
  import jpeg_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  hold,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic [8*COEF_W-1:0]   rd_data,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [8*OUT_W-1:0]    wr_data
);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] rd_cnt;
  logic              issue;
  logic              vd, v1;
  logic [ADDR_W-1:0] ad, a1;

  // Issue starts on the start edge itself so the first read lands in cycle 1.
  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nx = ST_RUN;
          issue    = !hold;
        end
      end
      ST_RUN: begin
        issue = !hold;
        if (!hold && rd_cnt == LAST_ROW) state_nx = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!rd_en && !vd && !v1) state_nx = ST_DONE;
      end
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      rd_cnt  <= '0;
      rd_en   <= 1'b0;
      rd_addr <= '0;
      vd      <= 1'b0;
      ad      <= '0;
      v1      <= 1'b0;
      a1      <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
    end else begin
      state <= state_nx;
      rd_en <= issue;
      if (issue) begin
        rd_addr <= rd_cnt;
        if (rd_cnt != LAST_ROW) rd_cnt <= rd_cnt + 1'b1;
      end
      if (state == ST_DONE) rd_cnt <= '0;
      vd      <= rd_en;
      ad      <= rd_addr;
      v1      <= vd;
      a1      <= ad;
      wr_en   <= v1;
      wr_addr <= a1;
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  // a1 travels alongside the lane's captured coefficient, so its low bits pick the table row.
  for (genvar g = 0; g < 8; g++) begin : g_lane
    quant_lane u_lane (
      .clk   (clk),
      .reset (reset),
      .coef  (rd_data[g*COEF_W +: COEF_W]),
      .recip (RECIP_TABLE[{a1[2:0], 3'(g), 4'd0} +: RECIP_W]),
      .q     (wr_data[g*OUT_W +: OUT_W])
    );
  end

endmodule

// File: tb/tb_dct_quantizer.sv
// tb/tb_dct_quantizer.sv - directed self-checking bench for dct_quantizer
module tb_dct_quantizer;

  localparam int N = 32768;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        hold;
  logic        busy, done, rd_en, wr_en;
  logic [14:0] rd_addr, wr_addr;
  logic [79:0] rd_data;
  logic [63:0] wr_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  logic mode_zero = 1'b0;

  dct_quantizer dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .hold    (hold),
    .busy    (busy),
    .done    (done),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [79:0] mem_word(input logic [14:0] a, input logic z);
    logic [79:0] w;
    w = '0;
    if (!z) begin
      if (a == 15'd0) begin
        w[9:0]   = 10'd160;
        w[19:10] = 10'h3df;
        w[29:20] = 10'd5;
        w[39:30] = 10'h3f8;
      end else if (a == 15'd1 || a == 15'd9) begin
        w[9:0]   = 10'h1ff;
        w[19:10] = 10'h200;
      end
    end
    return w;
  endfunction

  always @(posedge clk) if (rd_en) rd_data <= mem_word(rd_addr, mode_zero);

  // Write-side statistics, restarted whenever a start is accepted from idle.
  logic        strt_seen = 1'b0;
  int          wr_count = 0, addr_err = 0, nz_err = 0, first_wr = -1, busy_count = 0, seen_hold_rows = 0;
  logic [14:0] exp_addr = '0;
  logic [63:0] d0 = '0, d1 = '0, d9 = '0;

  always @(posedge clk) strt_seen <= start && !busy;

  always @(negedge clk) begin
    if (strt_seen) begin
      busy_count     <= busy ? 1 : 0;
      wr_count       <= 0;
      addr_err       <= 0;
      nz_err         <= 0;
      first_wr       <= -1;
      seen_hold_rows <= 0;
      exp_addr       <= '0;
      d0 <= '1; d1 <= '1; d9 <= '1;
    end else begin
      if (busy) busy_count <= busy_count + 1;
      if (wr_en) begin
        if (wr_count == 0) first_wr <= cyc - t0;
        if (wr_addr != exp_addr) addr_err <= addr_err + 1;
        exp_addr <= exp_addr + 1'b1;
        wr_count <= wr_count + 1;
        if (wr_addr >= 15'd98 && wr_addr <= 15'd100) seen_hold_rows <= seen_hold_rows + 1;
        case (wr_addr)
          15'd0:   d0 <= wr_data;
          15'd1:   d1 <= wr_data;
          15'd9:   d9 <= wr_data;
          default: if (wr_data != 64'd0) nz_err <= nz_err + 1;
        endcase
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic wait_done(output int rel);
    rel = -1;
    for (int k = 0; k < 40000; k++) begin
      @(negedge clk);
      if (done) begin
        rel = cyc - t0;
        break;
      end
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    t0 = cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  int rel;
  int found;
  int hold_rd;

  initial begin
    reset = 1'b0;
    start = 1'b0;
    hold  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rd_en",   64'(rd_en),   64'd0);
    check("rst_wr_en",   64'(wr_en),   64'd0);
    check("rst_busy",    64'(busy),    64'd0);
    check("rst_done",    64'(done),    64'd0);
    check("rst_rd_addr", 64'(rd_addr), 64'd0);
    check("rst_wr_addr", 64'(wr_addr), 64'd0);
    check("rst_wr_data", wr_data,      64'd0);
    reset = 1'b1;
    @(negedge clk);

    // Run 1: directed data, start pulse mid-run, 5-cycle hold after read 100.
    mode_zero = 1'b0;
    do_start();
    check("r1_first_rd_en",   64'(rd_en),   64'd1);
    check("r1_first_rd_addr", 64'(rd_addr), 64'd0);
    repeat (8) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (rd_en && rd_addr == 15'd100) begin
        found = 1;
        break;
      end
    end
    check("r1_saw_rd100", 64'(found), 64'd1);
    hold = 1'b1;
    hold_rd = 0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (rd_en) hold_rd++;
      if (i == 5) hold = 1'b0;
    end
    check("r1_rd_during_hold", 64'(hold_rd), 64'd0);
    @(negedge clk);
    check("r1_resume_rd_en",   64'(rd_en),   64'd1);
    check("r1_resume_rd_addr", 64'(rd_addr), 64'd101);
    wait_done(rel);
    check("r1_done_cycle", 64'(rel), 64'(N + 9));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("r1_no_rerun_busy",  64'(busy),  64'd0);
    check("r1_no_rerun_rd_en", 64'(rd_en), 64'd0);
    check("r1_wr_count",       64'(wr_count),       64'(N));
    check("r1_addr_order",     64'(addr_err),       64'd0);
    check("r1_zero_rows",      64'(nz_err),         64'd0);
    check("r1_first_wr",       64'(first_wr),       64'd4);
    check("r1_hold_rows",      64'(seen_hold_rows), 64'd3);
    check("r1_busy_cycles",    64'(busy_count),     64'(N + 9));
    check("r1_row0",           d0, 64'h00000000ff01fd0a);
    check("r1_addr9",          d9, 64'h000000000000d52b);
    check("r1_addr1_wrap",     d1, 64'h000000000000d52b);

    // Run 2: asynchronous reset at cycle 50 aborts the run.
    do_start();
    repeat (49) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("r2_abort_rd_en",   64'(rd_en),   64'd0);
    check("r2_abort_wr_en",   64'(wr_en),   64'd0);
    check("r2_abort_busy",    64'(busy),    64'd0);
    check("r2_abort_done",    64'(done),    64'd0);
    check("r2_abort_rd_addr", 64'(rd_addr), 64'd0);
    check("r2_abort_wr_addr", 64'(wr_addr), 64'd0);
    check("r2_abort_wr_data", wr_data,      64'd0);
    repeat (2) @(negedge clk);
    check("r2_held_rd_en", 64'(rd_en), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // Run 3: zero image, no hold, full run from address 0.
    mode_zero = 1'b1;
    do_start();
    check("r3_first_rd_addr", 64'(rd_addr), 64'd0);
    wait_done(rel);
    check("r3_done_cycle", 64'(rel), 64'(N + 4));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("r3_no_rerun_busy", 64'(busy),       64'd0);
    check("r3_wr_count",      64'(wr_count),   64'(N));
    check("r3_addr_order",    64'(addr_err),   64'd0);
    check("r3_zero_rows",     64'(nz_err),     64'd0);
    check("r3_first_wr",      64'(first_wr),   64'd4);
    check("r3_busy_cycles",   64'(busy_count), 64'(N + 4));
    check("r3_row0_zero",     d0, 64'd0);
    check("r3_row9_zero",     d9, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
